// File: rtl/arbitro_enrutador.sv
// arbitro_enrutador: arbitrates four source FIFOs (F0..F3) onto four destination FIFOs (P4..P7) through one register stage.
// Build option: define ROUND_ROBIN_EN for rotating grants; otherwise fixed priority F0 > F1 > F2 > F3.
module arbitro_enrutador #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty_F0,
    input  logic              empty_F1,
    input  logic              empty_F2,
    input  logic              empty_F3,
    input  logic [DATA_W-1:0] data_F0,
    input  logic [DATA_W-1:0] data_F1,
    input  logic [DATA_W-1:0] data_F2,
    input  logic [DATA_W-1:0] data_F3,
    input  logic              almost_full_P4,
    input  logic              almost_full_P5,
    input  logic              almost_full_P6,
    input  logic              almost_full_P7,
    input  logic              empty_P4,
    input  logic              empty_P5,
    input  logic              empty_P6,
    input  logic              empty_P7,
    output logic              pop_F0,
    output logic              pop_F1,
    output logic              pop_F2,
    output logic              pop_F3,
    output logic              push_P4,
    output logic              push_P5,
    output logic              push_P6,
    output logic              push_P7,
    output logic [DATA_W-1:0] data_out,
    output logic              IDLE
);

    logic [3:0]        src_empty;
    logic [DATA_W-1:0] src_data [4];
    logic [3:0]        dst_almost_full;
    logic [3:0]        dst_empty;

    assign src_empty       = {empty_F3, empty_F2, empty_F1, empty_F0};
    assign src_data[0]     = data_F0;
    assign src_data[1]     = data_F1;
    assign src_data[2]     = data_F2;
    assign src_data[3]     = data_F3;
    assign dst_almost_full = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};
    assign dst_empty       = {empty_P7, empty_P6, empty_P5, empty_P4};

    // A source may go only if its head word's destination can still take a word this cycle.
    logic [3:0] eligible;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = !src_empty[i] && !dst_almost_full[src_data[i][DATA_W-1 -: 2]];
        end
    end

    logic       grant_valid;
    logic [1:0] grant_idx;

`ifdef ROUND_ROBIN_EN
    // rr_ptr holds the source where the next search starts (one past the last grant).
    logic [1:0] rr_ptr;
    logic [1:0] candidate;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        candidate   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            candidate = rr_ptr + 2'(k);
            if (!grant_valid && eligible[candidate]) begin
                grant_valid = 1'b1;
                grant_idx   = candidate;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= 2'd0;
        end else if (grant_valid) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`else
    // Scanning downwards lets the lowest eligible index win.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(k);
            end
        end
    end
`endif

    logic [3:0] pop_vec;

    always_comb begin
        pop_vec = '0;
        if (reset && grant_valid) begin
            pop_vec[grant_idx] = 1'b1;
        end
    end

    assign pop_F0 = pop_vec[0];
    assign pop_F1 = pop_vec[1];
    assign pop_F2 = pop_vec[2];
    assign pop_F3 = pop_vec[3];

    logic [DATA_W-1:0] granted_word;
    logic [1:0]        granted_dest;

    assign granted_word = src_data[grant_idx];
    assign granted_dest = granted_word[DATA_W-1 -: 2];

    logic [3:0]        push_q;
    logic [DATA_W-1:0] data_q;
    logic              idle_q;

    // Idle looks at the push currently on the outputs, so a word still in flight keeps it low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push_q <= '0;
            data_q <= '0;
            idle_q <= 1'b0;
        end else begin
            push_q <= '0;
            if (grant_valid) begin
                push_q[granted_dest] <= 1'b1;
                data_q               <= granted_word;
            end
            idle_q <= (&src_empty) && (&dst_empty) && !(|push_q);
        end
    end

    assign push_P4  = push_q[0];
    assign push_P5  = push_q[1];
    assign push_P6  = push_q[2];
    assign push_P7  = push_q[3];
    assign data_out = data_q;
    assign IDLE     = idle_q;

endmodule
